// File: rtl/spike_window_controller.sv
`default_nettype none
// ============================================================================
//  Module   : spike_window_controller
//  Purpose  : Sequences one classification window over a bank of spike
//             counters: clear, run for W timesteps, settle, snapshot, then
//             serially scan the snapshot for the max-count (winning) neuron.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk            in   system clock, rising edge
//    rst_n          in   asynchronous reset, active low
//    start_i        in   begin a window (honoured in IDLE only)
//    abort_i        in   cancel the active window
//    window_len_i   in   timesteps in the window, captured with start_i
//    counter_in_i   in   flattened counts, neuron i at [i*COUNTER_SIZE +: COUNTER_SIZE]
//    counters_rst_o out  active-high clear to the spike counters
//    step_en_o      out  network timestep enable
//    busy_o         out  high in every state except IDLE
//    done_o         out  one-cycle pulse, winner outputs just updated
//    winner_idx_o   out  index of the max count (lowest index on ties)
//    winner_count_o out  max count value
//    winner_valid_o out  max count is nonzero
//    tie_o          out  another neuron shares the max count
// ============================================================================
module spike_window_controller #(
    parameter int NUM_INPUTS    = 4,
    parameter int COUNTER_SIZE  = 4,
    parameter int WINDOW_WIDTH  = 16,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                                                 clk,
    input  logic                                                 rst_n,
    input  logic                                                 start_i,
    input  logic                                                 abort_i,
    input  logic [WINDOW_WIDTH-1:0]                              window_len_i,
    input  logic [NUM_INPUTS*COUNTER_SIZE-1:0]                   counter_in_i,
    output logic                                                 counters_rst_o,
    output logic                                                 step_en_o,
    output logic                                                 busy_o,
    output logic                                                 done_o,
    output logic [((NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1)-1:0] winner_idx_o,
    output logic [COUNTER_SIZE-1:0]                              winner_count_o,
    output logic                                                 winner_valid_o,
    output logic                                                 tie_o
);

    localparam int c_idx_w = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int c_set_w = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [c_idx_w-1:0]      c_idx_one     = c_idx_w'(1);
    localparam logic [c_idx_w-1:0]      c_idx_last    = c_idx_w'(NUM_INPUTS - 1);
    localparam logic [c_set_w-1:0]      c_settle_last = c_set_w'(SETTLE_CYCLES - 1);
    localparam logic [c_set_w-1:0]      c_set_one     = c_set_w'(1);
    localparam logic [WINDOW_WIDTH-1:0] c_run_one     = {{(WINDOW_WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CLEAR  = 3'd1,
        S_RUN    = 3'd2,
        S_SETTLE = 3'd3,
        S_SCAN   = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t                           state_q, state_d;
    logic [WINDOW_WIDTH-1:0]          run_cnt_q;
    logic [c_set_w-1:0]               settle_cnt_q;
    logic [c_idx_w-1:0]               scan_idx_q;
    logic [NUM_INPUTS*COUNTER_SIZE-1:0] snap_q;
    logic [COUNTER_SIZE-1:0]          max_q, max_d;
    logic [c_idx_w-1:0]               best_q, best_d;
    logic                             tie_q, tie_d;
    logic                             abort_clr_q;

    logic                             start_ok;
    logic                             abort_act;
    logic                             scan_last;
    logic [COUNTER_SIZE-1:0]          cur_count;

    // Abort takes priority over start even in IDLE, so a simultaneous pair
    // never launches a window.
    assign start_ok  = (state_q == S_IDLE) && start_i && !abort_i;
    assign abort_act = (state_q != S_IDLE) && abort_i;
    assign scan_last = (state_q == S_SCAN) && (scan_idx_q == c_idx_last);
    assign cur_count = snap_q[int'(scan_idx_q)*COUNTER_SIZE +: COUNTER_SIZE];

    // ------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM next state and Moore outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d        = state_q;
        counters_rst_o = abort_clr_q;   // one-cycle clear after an abort
        step_en_o      = 1'b0;
        busy_o         = 1'b1;
        done_o         = 1'b0;
        case (state_q)
            S_IDLE: begin
                busy_o = 1'b0;
                if (start_ok) begin
                    state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                counters_rst_o = 1'b1;
                state_d        = (run_cnt_q == '0) ? S_SETTLE : S_RUN;
            end
            S_RUN: begin
                step_en_o = 1'b1;
                if (run_cnt_q == c_run_one) begin
                    state_d = S_SETTLE;
                end
            end
            S_SETTLE: begin
                if (settle_cnt_q == '0) begin
                    state_d = S_SCAN;
                end
            end
            S_SCAN: begin
                if (scan_last) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (abort_act) begin
            state_d = S_IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Running max comparison for the current scan slot
    // ------------------------------------------------------------------
    always_comb begin
        max_d  = max_q;
        best_d = best_q;
        tie_d  = tie_q;
        if (scan_idx_q == '0) begin
            max_d  = cur_count;
            best_d = '0;
            tie_d  = 1'b0;
        end else if (cur_count > max_q) begin
            max_d  = cur_count;
            best_d = scan_idx_q;
            tie_d  = 1'b0;
        end else if (cur_count == max_q) begin
            tie_d = 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt_q      <= '0;
            settle_cnt_q   <= '0;
            scan_idx_q     <= '0;
            snap_q         <= '0;
            max_q          <= '0;
            best_q         <= '0;
            tie_q          <= 1'b0;
            abort_clr_q    <= 1'b0;
            winner_idx_o   <= '0;
            winner_count_o <= '0;
            winner_valid_o <= 1'b0;
            tie_o          <= 1'b0;
        end else begin
            abort_clr_q <= abort_act;

            // Window length doubles as the RUN down-counter.
            if (start_ok) begin
                run_cnt_q <= window_len_i;
            end else if (state_q == S_RUN) begin
                run_cnt_q <= run_cnt_q - c_run_one;
            end

            if (state_q == S_SETTLE) begin
                settle_cnt_q <= settle_cnt_q - c_set_one;
            end else begin
                settle_cnt_q <= c_settle_last;
            end

            // Counters are spike-clocked; sample them only once they settle.
            if ((state_q == S_SETTLE) && (settle_cnt_q == '0)) begin
                snap_q <= counter_in_i;
            end

            if (state_q == S_SCAN) begin
                scan_idx_q <= scan_idx_q + c_idx_one;
                max_q      <= max_d;
                best_q     <= best_d;
                tie_q      <= tie_d;
            end else begin
                scan_idx_q <= '0;
            end

            // Results change only when DONE is actually entered.
            if (scan_last && !abort_i) begin
                winner_idx_o   <= best_d;
                winner_count_o <= max_d;
                winner_valid_o <= (max_d != '0);
                tie_o          <= tie_d;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_spike_window_controller.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spike_window_controller
//  Purpose  : Directed self-checking bench for spike_window_controller with
//             hand-computed expected timing and winner results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_spike_window_controller;

    localparam int NI = 4;
    localparam int CS = 4;
    localparam int WW = 16;
    localparam int SC = 2;

    logic          clk;
    logic          rst_n;
    logic          start_i;
    logic          abort_i;
    logic [WW-1:0] window_len_i;
    logic [NI*CS-1:0] counter_in_i;
    logic          counters_rst_o;
    logic          step_en_o;
    logic          busy_o;
    logic          done_o;
    logic [1:0]    winner_idx_o;
    logic [CS-1:0] winner_count_o;
    logic          winner_valid_o;
    logic          tie_o;

    int errors = 0;
    int checks = 0;

    // Window monitor results
    int step_cnt;
    int done_cnt;
    int done_cyc;
    int crst_cnt;
    int busy_end;

    spike_window_controller #(
        .NUM_INPUTS    (NI),
        .COUNTER_SIZE  (CS),
        .WINDOW_WIDTH  (WW),
        .SETTLE_CYCLES (SC)
    ) u_dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .window_len_i   (window_len_i),
        .counter_in_i   (counter_in_i),
        .counters_rst_o (counters_rst_o),
        .step_en_o      (step_en_o),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .winner_idx_o   (winner_idx_o),
        .winner_count_o (winner_count_o),
        .winner_valid_o (winner_valid_o),
        .tie_o          (tie_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Launch a window and observe cycles 1..budget (cycle 0 samples start).
    // A stray start is pulsed at ign_cyc and abort at abort_cyc (0 = none).
    task automatic run_window(input int w, input logic [NI*CS-1:0] counts,
                              input int budget, input int ign_cyc, input int abort_cyc);
        step_cnt = 0;
        done_cnt = 0;
        done_cyc = -1;
        crst_cnt = 0;
        @(negedge clk);
        counter_in_i = counts;
        window_len_i = WW'(w);
        start_i      = 1'b1;
        for (int c = 1; c <= budget; c++) begin
            @(negedge clk);
            if (step_en_o)      step_cnt++;
            if (counters_rst_o) crst_cnt++;
            if (done_o) begin
                done_cnt++;
                if (done_cyc < 0) done_cyc = c;
            end
            start_i = (c == ign_cyc);
            if (c == ign_cyc) window_len_i = WW'(3);
            abort_i = (c == abort_cyc);
        end
        busy_end = busy_o;
        start_i  = 1'b0;
        abort_i  = 1'b0;
    endtask

    task automatic check_results(input string tag, input int idx, input int cnt,
                                 input int vld, input int tie);
        check({tag, "_idx"},   32'(winner_idx_o),   32'(idx));
        check({tag, "_count"}, 32'(winner_count_o), 32'(cnt));
        check({tag, "_valid"}, 32'(winner_valid_o), 32'(vld));
        check({tag, "_tie"},   32'(tie_o),          32'(tie));
    endtask

    initial begin
        rst_n        = 1'b0;
        start_i      = 1'b0;
        abort_i      = 1'b0;
        window_len_i = '0;
        counter_in_i = '0;
        #1;
        check("rst_busy",     32'(busy_o),         32'd0);
        check("rst_crst",     32'(counters_rst_o), 32'd0);
        check("rst_step",     32'(step_en_o),      32'd0);
        check("rst_done",     32'(done_o),         32'd0);
        check_results("rst", 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // W=10, counts {3,9,5,1}; a stray start with W=3 at cycle 5 is ignored
        run_window(10, 16'h1593, 22, 5, 0);
        check("w10_steps",    32'(step_cnt), 32'd10);
        check("w10_done_cyc", 32'(done_cyc), 32'd18);
        check("w10_done_cnt", 32'(done_cnt), 32'd1);
        check("w10_crst",     32'(crst_cnt), 32'd1);
        check("w10_busy_end", 32'(busy_end), 32'd0);
        check_results("w10", 1, 9, 1, 0);

        // Reset asserted mid-RUN clears everything immediately
        @(negedge clk);
        window_len_i = WW'(10);
        start_i      = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (3) @(negedge clk);
        check("midrun_step",  32'(step_en_o), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("arst_busy", 32'(busy_o),         32'd0);
        check("arst_step", 32'(step_en_o),      32'd0);
        check("arst_done", 32'(done_o),         32'd0);
        check("arst_crst", 32'(counters_rst_o), 32'd0);
        check_results("arst", 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // W=0, all counts zero
        run_window(0, 16'h0000, 12, 0, 0);
        check("w0_steps",    32'(step_cnt), 32'd0);
        check("w0_done_cyc", 32'(done_cyc), 32'd8);
        check("w0_crst",     32'(crst_cnt), 32'd1);
        check_results("w0", 0, 0, 0, 1);

        // Three-way tie at 7, lowest index wins
        run_window(3, 16'h7727, 15, 0, 0);
        check("tie_done_cyc", 32'(done_cyc), 32'd11);
        check_results("tie", 0, 7, 1, 1);

        // Abort at cycle 5 of W=10; stray start at cycle 3 ignored
        run_window(10, 16'hFFFF, 30, 3, 5);
        check("abort_steps",    32'(step_cnt), 32'd4);
        check("abort_crst",     32'(crst_cnt), 32'd2);
        check("abort_done_cnt", 32'(done_cnt), 32'd0);
        check("abort_busy_end", 32'(busy_end), 32'd0);
        check_results("abort", 0, 7, 1, 1);

        // Abort together with start in IDLE: nothing happens
        @(negedge clk);
        start_i      = 1'b1;
        abort_i      = 1'b1;
        window_len_i = WW'(5);
        @(negedge clk);
        start_i = 1'b0;
        abort_i = 1'b0;
        check("idle_abort_busy", 32'(busy_o),         32'd0);
        check("idle_abort_crst", 32'(counters_rst_o), 32'd0);
        @(negedge clk);

        // Maximum window length, winner in the last slot
        run_window(65535, 16'hF000, 65550, 0, 0);
        check("wmax_steps",    32'(step_cnt), 32'd65535);
        check("wmax_done_cyc", 32'(done_cyc), 32'd65543);
        check("wmax_done_cnt", 32'(done_cnt), 32'd1);
        check_results("wmax", 3, 15, 1, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
